// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the clear-sequencer state encoding and the default parameter values.
// No ports; imported by the interface, the sequencer and the top.
package rf_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } clr_state_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: two write ports, packed read ports, clear control.
// master: drives writes, read addresses and CLEAR; sees DATA_OUT, BUSY, WRITE_REJECT.
// slave : the register file side of the same signals.
interface reg_file_mp_if
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
);
    logic                       WRITE_ENABLE0;
    logic [ADDR_W-1:0]          WRITE_ADDR0;
    logic [DATA_W-1:0]          WRITE_DATA0;
    logic                       WRITE_ENABLE1;
    logic [ADDR_W-1:0]          WRITE_ADDR1;
    logic [DATA_W-1:0]          WRITE_DATA1;
    logic [NUM_RD*ADDR_W-1:0]   OUT_ADDR;
    logic [NUM_RD*DATA_W-1:0]   DATA_OUT;
    logic                       CLEAR;
    logic                       BUSY;
    logic                       WRITE_REJECT;

    modport master (
        output WRITE_ENABLE0, WRITE_ADDR0, WRITE_DATA0,
        output WRITE_ENABLE1, WRITE_ADDR1, WRITE_DATA1,
        output OUT_ADDR, CLEAR,
        input  DATA_OUT, BUSY, WRITE_REJECT
    );

    modport slave (
        input  WRITE_ENABLE0, WRITE_ADDR0, WRITE_DATA0,
        input  WRITE_ENABLE1, WRITE_ADDR1, WRITE_DATA1,
        input  OUT_ADDR, CLEAR,
        output DATA_OUT, BUSY, WRITE_REJECT
    );

endinterface

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks an index over every register, one per cycle.
// Ports: i_clk, i_rst_n (sync active-low), i_clear (start pulse),
//        o_busy (registered, high for 2**ADDR_W cycles), o_idx (register to zero this cycle).
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_idx
);

    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear) begin
                        r_state <= ST_CLEARING;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEARING: begin
                    // A CLEAR arriving here is ignored; the sweep always runs to the end.
                    if (r_idx == {ADDR_W{1'b1}}) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_idx  = r_idx;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 write ports (port 1 wins), NUM_RD combinational read ports,
// optional zero register, optional write-to-read bypass, bulk clear via rf_clear_seq.
// Ports: CLK, RESET (sync active-low), bus (reg_file_mp_if.slave).
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic           CLK,
    input  logic           RESET,
    reg_file_mp_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic                     r_reject;
    logic                     w_busy;
    logic [ADDR_W-1:0]        w_clr_idx;
    logic                     w_wr0;
    logic                     w_wr1;
    logic [DATA_W-1:0]        w_rdat [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] w_dout;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_clear (bus.CLEAR),
        .o_busy  (w_busy),
        .o_idx   (w_clr_idx)
    );

    // Writes only take effect outside a clear; address 0 is never stored when hardwired.
    assign w_wr0 = bus.WRITE_ENABLE0 && !w_busy &&
                   !((ZERO_REG != 0) && (bus.WRITE_ADDR0 == '0));
    assign w_wr1 = bus.WRITE_ENABLE1 && !w_busy &&
                   !((ZERO_REG != 0) && (bus.WRITE_ADDR1 == '0));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_mem    <= '{default: '0};
            r_reject <= 1'b0;
        end else begin
            r_reject <= w_busy && (bus.WRITE_ENABLE0 || bus.WRITE_ENABLE1);
            if (w_busy) begin
                r_mem[w_clr_idx] <= '0;
            end else begin
                // Port 1 is assigned last so it wins a same-address collision.
                if (w_wr0) r_mem[bus.WRITE_ADDR0] <= bus.WRITE_DATA0;
                if (w_wr1) r_mem[bus.WRITE_ADDR1] <= bus.WRITE_DATA1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = bus.OUT_ADDR[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_mem[w_ra];
            // w_wr* already excludes the clearing state, so bypass is off then too.
            if (BYPASS != 0) begin
                if (w_wr1 && (bus.WRITE_ADDR1 == w_ra)) begin
                    w_rd = bus.WRITE_DATA1;
                end else if (w_wr0 && (bus.WRITE_ADDR0 == w_ra)) begin
                    w_rd = bus.WRITE_DATA0;
                end
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign w_rdat[k] = w_rd;
    end

    always_comb begin
        w_dout = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_dout[k*DATA_W +: DATA_W] = w_rdat[k];
        end
    end

    assign bus.DATA_OUT     = w_dout;
    assign bus.BUSY         = w_busy;
    assign bus.WRITE_REJECT = r_reject;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default instance plus a narrow no-bypass instance.
// No latency under test beyond combinational reads and one-cycle registered flags.
// Inputs are driven 1ns after the rising edge and outputs sampled 1ns after that.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reg_file_mp_if a ();
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) b ();

    reg_file_mp u_a (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (a)
    );

    reg_file_mp #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .NUM_RD   (4),
        .ZERO_REG (1),
        .BYPASS   (0)
    ) u_b (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a.WRITE_ENABLE0 = 1'b0;
        a.WRITE_ENABLE1 = 1'b0;
        a.CLEAR         = 1'b0;
    endtask

    // Only valid while nothing is changing state (no writes, no clear in progress).
    task automatic scan_a(output int nz);
        nz = 0;
        for (int i = 0; i < 32; i++) begin
            a.OUT_ADDR = {5'd0, 5'(i)};
            #1;
            if (a.DATA_OUT[31:0] != 32'd0) nz++;
        end
    endtask

    int busy_cnt;
    int rej_cnt;
    int nz;

    initial begin
        rst_n = 1'b0;
        a.WRITE_ENABLE0 = 1'b0; a.WRITE_ADDR0 = '0; a.WRITE_DATA0 = '0;
        a.WRITE_ENABLE1 = 1'b0; a.WRITE_ADDR1 = '0; a.WRITE_DATA1 = '0;
        a.OUT_ADDR = '0; a.CLEAR = 1'b0;
        b.WRITE_ENABLE0 = 1'b0; b.WRITE_ADDR0 = '0; b.WRITE_DATA0 = '0;
        b.WRITE_ENABLE1 = 1'b0; b.WRITE_ADDR1 = '0; b.WRITE_DATA1 = '0;
        b.OUT_ADDR = '0; b.CLEAR = 1'b0;

        step(); step();
        chk("rst_busy", 32'(a.BUSY), 0);
        chk("rst_reject", 32'(a.WRITE_REJECT), 0);
        scan_a(nz);
        chk("rst_all_zero", nz, 0);
        rst_n = 1'b1;
        step();

        // Basic write / read on two ports.
        a.WRITE_ENABLE0 = 1'b1; a.WRITE_ADDR0 = 5'd1; a.WRITE_DATA0 = 32'd42;
        step();
        idle_a();
        a.OUT_ADDR = {5'd0, 5'd1};
        #1;
        chk("wr_r1_p0", a.DATA_OUT[31:0], 42);
        chk("wr_r1_p1_r0", a.DATA_OUT[63:32], 0);

        // Same-address collision: port 1 wins, visible same cycle via bypass.
        step();
        a.WRITE_ENABLE0 = 1'b1; a.WRITE_ADDR0 = 5'd3; a.WRITE_DATA0 = 32'd5;
        a.WRITE_ENABLE1 = 1'b1; a.WRITE_ADDR1 = 5'd3; a.WRITE_DATA1 = 32'd9;
        a.OUT_ADDR = {5'd3, 5'd3};
        #1;
        chk("coll_bypass", a.DATA_OUT[31:0], 9);
        step();
        idle_a();
        #1;
        chk("coll_stored", a.DATA_OUT[63:32], 9);

        // Port-0-only bypass.
        a.WRITE_ENABLE0 = 1'b1; a.WRITE_ADDR0 = 5'd4; a.WRITE_DATA0 = 32'd11;
        a.OUT_ADDR = {5'd4, 5'd3};
        #1;
        chk("bypass_p0", a.DATA_OUT[63:32], 11);
        step();
        idle_a();

        // Zero register.
        a.WRITE_ENABLE0 = 1'b1; a.WRITE_ADDR0 = 5'd0; a.WRITE_DATA0 = 32'd123;
        a.OUT_ADDR = {5'd0, 5'd0};
        #1;
        chk("r0_during", a.DATA_OUT[31:0], 0);
        step();
        idle_a();
        #1;
        chk("r0_after", a.DATA_OUT[63:32], 0);

        // Fill r1..r31 with their index.
        for (int i = 1; i < 32; i++) begin
            a.WRITE_ENABLE0 = 1'b1; a.WRITE_ADDR0 = 5'(i); a.WRITE_DATA0 = 32'(i);
            step();
        end
        idle_a();
        a.OUT_ADDR = {5'd31, 5'd17};
        #1;
        chk("fill_r17", a.DATA_OUT[31:0], 17);
        chk("fill_r31", a.DATA_OUT[63:32], 31);

        // Bulk clear: register k is zeroed at edge k+1 after the CLEAR edge.
        a.CLEAR = 1'b1;
        step();
        busy_cnt = 0;
        rej_cnt  = 0;
        for (int c = 0; c < 40; c++) begin
            idle_a();
            if (a.BUSY) busy_cnt++;
            if (a.WRITE_REJECT) rej_cnt++;
            if (c == 1) begin
                a.OUT_ADDR = {5'd31, 5'd20};
                #1;
                chk("clr_read_r20", a.DATA_OUT[31:0], 20);
            end
            if (c == 10) begin
                a.WRITE_ENABLE0 = 1'b1; a.WRITE_ADDR0 = 5'd5;  a.WRITE_DATA0 = 32'd77;
                a.WRITE_ENABLE1 = 1'b1; a.WRITE_ADDR1 = 5'd30; a.WRITE_DATA1 = 32'd88;
                a.OUT_ADDR = {5'd30, 5'd5};
                #1;
                chk("clr_nobypass_r5", a.DATA_OUT[31:0], 0);
                chk("clr_nobypass_r30", a.DATA_OUT[63:32], 30);
            end
            if (c == 11) chk("clr_reject_pulse", 32'(a.WRITE_REJECT), 1);
            if (c == 15) a.CLEAR = 1'b1;
            step();
        end
        idle_a();
        chk("clr_busy_cycles", busy_cnt, 32);
        chk("clr_reject_count", rej_cnt, 1);
        scan_a(nz);
        chk("clr_all_zero", nz, 0);

        // Reset in the middle of a clear.
        a.WRITE_ENABLE0 = 1'b1; a.WRITE_ADDR0 = 5'd9; a.WRITE_DATA0 = 32'd99;
        a.WRITE_ENABLE1 = 1'b1; a.WRITE_ADDR1 = 5'd2; a.WRITE_DATA1 = 32'd2;
        step();
        idle_a();
        a.CLEAR = 1'b1;
        step();
        a.CLEAR = 1'b0;
        step(); step(); step();
        chk("mid_busy_before", 32'(a.BUSY), 1);
        rst_n = 1'b0;
        a.WRITE_ENABLE0 = 1'b1; a.WRITE_ADDR0 = 5'd6; a.WRITE_DATA0 = 32'd66;
        step();
        idle_a();
        chk("mid_busy_after_rst", 32'(a.BUSY), 0);
        chk("mid_reject_after_rst", 32'(a.WRITE_REJECT), 0);
        rst_n = 1'b1;
        step();
        chk("mid_reject_after_rel", 32'(a.WRITE_REJECT), 0);
        scan_a(nz);
        chk("mid_all_zero", nz, 0);
        step();
        a.WRITE_ENABLE0 = 1'b1; a.WRITE_ADDR0 = 5'd2; a.WRITE_DATA0 = 32'd7;
        step();
        idle_a();
        a.OUT_ADDR = {5'd0, 5'd2};
        #1;
        chk("post_rst_r2", a.DATA_OUT[31:0], 7);

        // Narrow instance without bypass.
        step();
        b.WRITE_ENABLE0 = 1'b1; b.WRITE_ADDR0 = 3'd4; b.WRITE_DATA0 = 16'h1234;
        b.OUT_ADDR = {4{3'd4}};
        #1;
        chk("b_old_p0", 32'(b.DATA_OUT[15:0]), 0);
        chk("b_old_p3", 32'(b.DATA_OUT[63:48]), 0);
        step();
        b.WRITE_ENABLE0 = 1'b0;
        #1;
        chk("b_new_p2", 32'(b.DATA_OUT[47:32]), 32'h1234);
        b.WRITE_ENABLE0 = 1'b1; b.WRITE_ADDR0 = 3'd4; b.WRITE_DATA0 = 16'h1111;
        b.WRITE_ENABLE1 = 1'b1; b.WRITE_ADDR1 = 3'd4; b.WRITE_DATA1 = 16'h5678;
        #1;
        chk("b_old_p1", 32'(b.DATA_OUT[31:16]), 32'h1234);
        step();
        b.WRITE_ENABLE0 = 1'b0;
        b.WRITE_ENABLE1 = 1'b0;
        #1;
        chk("b_coll_p0", 32'(b.DATA_OUT[15:0]), 32'h5678);
        b.CLEAR = 1'b1;
        step();
        b.CLEAR = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (b.BUSY) busy_cnt++;
            step();
        end
        chk("b_busy_cycles", busy_cnt, 8);
        #1;
        chk("b_cleared_r4", 32'(b.DATA_OUT[15:0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, range 1..4, meaning number of read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled.
REQ-006 CLK  input  1  single clock; all state changes on rising edge.
REQ-007 RESET  input  1  synchronous, active-low reset.
REQ-008 WRITE_ENABLE0 / WRITE_ADDR0 / WRITE_DATA0  input  1 / ADDR_W / DATA_W  write port 0.
REQ-009 WRITE_ENABLE1 / WRITE_ADDR1 / WRITE_DATA1  input  1 / ADDR_W / DATA_W  write port 1.
REQ-010 OUT_ADDR  input  NUM_RD*ADDR_W  packed read addresses; port k in bits [k*ADDR_W +: ADDR_W].
REQ-011 DATA_OUT  output  NUM_RD*DATA_W  packed read data; port k in bits [k*DATA_W +: DATA_W].
REQ-012 CLEAR  input  1  one-cycle request to start a bulk clear.
REQ-013 BUSY  output  1  high while a bulk clear runs.
REQ-014 WRITE_REJECT  output  1  registered pulse: a write was dropped the previous cycle.

Function
REQ-015 Reads SHALL be combinational: DATA_OUT[k] = contents of register OUT_ADDR[k], zero latency.
REQ-016 Writes SHALL commit on the rising CLK edge when WRITE_ENABLEn=1, FSM in IDLE, RESET=1.
REQ-017 Both ports writing the same address in one cycle SHALL store WRITE_DATA1 (port 1 priority).
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0, including via bypass.
REQ-019 With BYPASS=1 in IDLE, a read matching an enabled write address SHALL return that write's data in the same cycle, port 1 over port 0.
REQ-020 With BYPASS=0, reads SHALL return stored contents only.
REQ-021 The clear FSM SHALL have states IDLE and CLEARING plus an ADDR_W-bit index counter.
REQ-022 IDLE -> CLEARING on CLEAR=1; counter loads 0; BUSY=1 from the next cycle.
REQ-023 In CLEARING, each cycle SHALL zero register[counter] and increment counter.
REQ-024 CLEARING -> IDLE in the cycle register[2**ADDR_W-1] is zeroed; total BUSY duration = 2**ADDR_W cycles.
REQ-025 CLEAR while CLEARING SHALL be ignored (no restart).
REQ-026 Any enabled write during CLEARING SHALL be dropped and WRITE_REJECT SHALL be 1 the following cycle; bypass disabled while CLEARING.
REQ-027 Reads during CLEARING SHALL return current stored contents (cleared or not).
REQ-028 CLEAR and a write in the same IDLE cycle: the write SHALL commit, then clearing starts next cycle.

Reset
REQ-029 RESET=0 at a rising edge SHALL zero all registers, set FSM IDLE, counter 0, BUSY 0, WRITE_REJECT 0.
REQ-030 RESET=0 mid-clear SHALL abort the clear; writes during reset SHALL be dropped without WRITE_REJECT.

Structure
REQ-031 FSM state encoding and default parameter values SHALL live in a shared package rf_pkg.
REQ-032 The clear sequencer (FSM, counter, BUSY) SHALL be one sub-module rf_clear_seq; storage, write arbitration and read/bypass muxing stay in reg_file_mp.

Verification
REQ-033 Reset, write 42 to r1 via port 0, read ports 0/1 at r1/r0 -> 42 / 0.
REQ-034 Port 0 writes 5 and port 1 writes 9 to r3 same cycle -> r3 reads 9 next cycle; during that cycle a read of r3 returns 9 (bypass).
REQ-035 Write 123 to r0 -> r0 reads 0 both during and after the write cycle.
REQ-036 Fill r1..r31 with index values, pulse CLEAR -> BUSY high exactly 32 cycles; write 77 to r5 at cycle 10 -> dropped, WRITE_REJECT pulses once; afterwards all registers read 0.
REQ-037 Start clear, assert RESET=0 at cycle 4 -> BUSY 0 next cycle, all registers 0, write 7 to r2 commits after RESET returns high.
REQ-038 Parameter sweep DATA_W=16, ADDR_W=3, NUM_RD=4, BYPASS=0 -> same-cycle read of written address returns old value; clear takes 8 cycles.
